// File: rtl/viol_reset_ctrl.sv
// Merges per-monitor violation lines into one stretched MCU system reset with sticky cause and saturating count.
// Optional macro VIOL_CAUSE_CLR_EN adds a cause_clr port that clears viol_cause while running.
module viol_reset_ctrl #(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] viol_in,
  input  logic [15:0]        pc,
`ifdef VIOL_CAUSE_CLR_EN
  input  logic               cause_clr,
`endif
  output logic               system_reset,
  output logic [NUM_SRC-1:0] viol_cause,
  output logic [CNT_W-1:0]   viol_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    WAIT_VEC = 2'd2
  } state_t;

  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state, state_nx;
  logic [7:0]         hold_cnt, hold_nx;
  logic [NUM_SRC-1:0] cause_nx;
  logic [CNT_W-1:0]   count_nx, count_sat;
  logic               any_viol, clr_req;

  assign any_viol  = |viol_in;
  assign count_sat = (viol_count == '1) ? viol_count : viol_count + CNT_ONE;

`ifdef VIOL_CAUSE_CLR_EN
  assign clr_req = cause_clr;
`else
  assign clr_req = 1'b0;
`endif

  assign system_reset = rst | (state == HOLD) | any_viol;
  assign busy         = (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      hold_cnt   <= '0;
      viol_cause <= '0;
      viol_count <= '0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      viol_cause <= cause_nx;
      viol_count <= count_nx;
    end
  end

  // The violation cycle seen in RUN/WAIT_VEC already drives system_reset, so HOLD
  // exits when hold_cnt reaches 1: entry cycle plus HOLD cycles equals HOLD_CYCLES.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    cause_nx = viol_cause;
    count_nx = viol_count;
    case (state)
      RUN: begin
        if (any_viol) begin
          state_nx = HOLD;
          hold_nx  = HOLD_LOAD;
          cause_nx = viol_cause | viol_in;
          count_nx = count_sat;
        end else if (clr_req) begin
          cause_nx = '0;
        end
      end
      HOLD: begin
        cause_nx = viol_cause | viol_in;
        if (hold_cnt > 8'd1) begin
          hold_nx = hold_cnt - 8'd1;
        end else if (any_viol) begin
          hold_nx = HOLD_LOAD;
        end else begin
          state_nx = WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (any_viol) begin
          state_nx = HOLD;
          hold_nx  = HOLD_LOAD;
          cause_nx = viol_cause | viol_in;
          count_nx = count_sat;
        end else if (pc == RESET_HANDLER) begin
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// Directed scoreboard bench for viol_reset_ctrl (default parameters, HOLD_CYCLES=16).
module tb_viol_reset_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  viol_in;
  logic [15:0] pc;
`ifdef VIOL_CAUSE_CLR_EN
  logic        cause_clr;
`endif
  logic        system_reset;
  logic [3:0]  viol_cause;
  logic [7:0]  viol_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       sr;
    logic       bsy;
    logic [3:0] cause;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];

  viol_reset_ctrl #(
    .NUM_SRC      (4),
    .HOLD_CYCLES  (16),
    .CNT_W        (8),
    .RESET_HANDLER(16'hFFFE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .viol_in     (viol_in),
    .pc          (pc),
`ifdef VIOL_CAUSE_CLR_EN
    .cause_clr   (cause_clr),
`endif
    .system_reset(system_reset),
    .viol_cause  (viol_cause),
    .viol_count  (viol_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic sr, input logic bsy,
                      input logic [3:0] c, input logic [7:0] n);
    exp_t e;
    e.tag = tag; e.sr = sr; e.bsy = bsy; e.cause = c; e.count = n;
    sb.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (system_reset === e.sr) else begin
        failures++;
        $error("FAIL %s system_reset observed=%b expected=%b", e.tag, system_reset, e.sr);
      end
      checks++;
      assert (busy === e.bsy) else begin
        failures++;
        $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.bsy);
      end
      checks++;
      assert (viol_cause === e.cause) else begin
        failures++;
        $error("FAIL %s viol_cause observed=%b expected=%b", e.tag, viol_cause, e.cause);
      end
      checks++;
      assert (viol_count === e.count) else begin
        failures++;
        $error("FAIL %s viol_count observed=%0d expected=%0d", e.tag, viol_count, e.count);
      end
    end
  endtask

  // Drive one cycle of inputs, then check outputs mid-cycle.
  task automatic cyc(input logic [3:0] v, input logic [15:0] p, input logic r, input string tag,
                     input logic sr, input logic bsy, input logic [3:0] c, input logic [7:0] n);
    @(posedge clk);
    #1;
    viol_in = v;
    pc      = p;
    rst     = r;
    push(tag, sr, bsy, c, n);
    compare_outputs();
  endtask

  task automatic wait_sr_low(input string tag, input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      viol_in = '0;
      pc      = '0;
      rst     = 1'b0;
      @(negedge clk);
      if (system_reset === 1'b0) seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL %s release_timeout observed=still_high expected=low_within_%0d", tag, budget);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    @(posedge clk);
    #1;
    viol_in = v;
    pc      = '0;
    rst     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    viol_in = '0;
    pc      = '0;
`ifdef VIOL_CAUSE_CLR_EN
    cause_clr = 1'b0;
`endif
    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b1, 1'b0, 4'b0000, 8'd0);
    compare_outputs();
    cyc(4'b0000, 16'h0000, 1'b0, "idle", 1'b0, 1'b0, 4'b0000, 8'd0);

    // 2: single-cycle violation -> 16-cycle reset, then wait for vector fetch
    cyc(4'b0001, 16'h0000, 1'b0, "s2_entry", 1'b1, 1'b0, 4'b0000, 8'd0);
    for (int i = 1; i <= 15; i++)
      cyc(4'b0000, 16'h0000, 1'b0, "s2_hold", 1'b1, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s2_release", 1'b0, 1'b1, 4'b0001, 8'd1);
    for (int i = 0; i < 3; i++)
      cyc(4'b0000, 16'h1234, 1'b0, "s2_wait", 1'b0, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'hFFFE, 1'b0, "s2_vec", 1'b0, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s2_run", 1'b0, 1'b0, 4'b0001, 8'd1);

    // 3: second source during hold merges cause, no width extension
    cyc(4'b0000, 16'h0000, 1'b1, "s3_rst", 1'b1, 1'b0, 4'b0001, 8'd1);
    cyc(4'b0001, 16'h0000, 1'b0, "s3_entry", 1'b1, 1'b0, 4'b0000, 8'd0);
    for (int i = 1; i <= 15; i++)
      cyc((i == 5) ? 4'b0100 : 4'b0000, 16'h0000, 1'b0, "s3_hold", 1'b1, 1'b1,
          (i <= 5) ? 4'b0001 : 4'b0101, 8'd1);
    cyc(4'b0000, 16'hFFFE, 1'b0, "s3_release", 1'b0, 1'b1, 4'b0101, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s3_run", 1'b0, 1'b0, 4'b0101, 8'd1);

    // 4: held violation keeps reset high; pulse in WAIT_VEC re-enters HOLD
    cyc(4'b0000, 16'h0000, 1'b1, "s4_rst", 1'b1, 1'b0, 4'b0101, 8'd1);
    cyc(4'b0010, 16'h0000, 1'b0, "s4_entry", 1'b1, 1'b0, 4'b0000, 8'd0);
    for (int i = 1; i < 40; i++)
      cyc(4'b0010, 16'h0000, 1'b0, "s4_held", 1'b1, 1'b1, 4'b0010, 8'd1);
    wait_sr_low("s4_release", 32);
    cyc(4'b0000, 16'h0000, 1'b0, "s4_wait", 1'b0, 1'b1, 4'b0010, 8'd1);
    cyc(4'b0001, 16'h0000, 1'b0, "s4_pulse", 1'b1, 1'b1, 4'b0010, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s4_reentry", 1'b1, 1'b1, 4'b0011, 8'd2);

    // 5: violation beats pc match in WAIT_VEC
    wait_sr_low("s5_release", 32);
    cyc(4'b1000, 16'hFFFE, 1'b0, "s5_both", 1'b1, 1'b1, 4'b0011, 8'd2);
    cyc(4'b0000, 16'h0000, 1'b0, "s5_hold", 1'b1, 1'b1, 4'b1011, 8'd3);

    // 6: rst mid-hold clears everything
    cyc(4'b0000, 16'h0000, 1'b1, "s6_rst_a", 1'b1, 1'b1, 4'b1011, 8'd3);
    cyc(4'b0001, 16'h0000, 1'b0, "s6_entry", 1'b1, 1'b0, 4'b0000, 8'd0);
    cyc(4'b0000, 16'h0000, 1'b0, "s6_hold1", 1'b1, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s6_hold2", 1'b1, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b1, "s6_rst_b", 1'b1, 1'b1, 4'b0001, 8'd1);
    cyc(4'b0000, 16'h0000, 1'b0, "s6_after", 1'b0, 1'b0, 4'b0000, 8'd0);

    // count saturation at all-ones
    for (int i = 0; i < 255; i++) begin
      pulse(4'b0001);
      wait_sr_low("sat_release", 32);
    end
    cyc(4'b0000, 16'h0000, 1'b0, "sat_max", 1'b0, 1'b1, 4'b0001, 8'hFF);
    pulse(4'b0001);
    wait_sr_low("sat_release_last", 32);
    cyc(4'b0000, 16'h0000, 1'b0, "sat_hold", 1'b0, 1'b1, 4'b0001, 8'hFF);
    cyc(4'b0000, 16'hFFFE, 1'b0, "sat_vec", 1'b0, 1'b1, 4'b0001, 8'hFF);
    cyc(4'b0000, 16'h0000, 1'b0, "sticky_run", 1'b0, 1'b0, 4'b0001, 8'hFF);

`ifdef VIOL_CAUSE_CLR_EN
    @(posedge clk);
    #1;
    cause_clr = 1'b1; viol_in = 4'b0000; pc = '0;
    push("clr_req", 1'b0, 1'b0, 4'b0001, 8'hFF);
    compare_outputs();
    @(posedge clk);
    #1;
    cause_clr = 1'b0;
    push("clr_done", 1'b0, 1'b0, 4'b0000, 8'hFF);
    compare_outputs();
    @(posedge clk);
    #1;
    cause_clr = 1'b1; viol_in = 4'b0100;
    push("clr_vs_viol", 1'b1, 1'b0, 4'b0000, 8'hFF);
    compare_outputs();
    @(posedge clk);
    #1;
    cause_clr = 1'b0; viol_in = 4'b0000;
    push("viol_wins", 1'b1, 1'b1, 4'b0100, 8'hFF);
    compare_outputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
